mux_arbiter_4: RTL
==================

# mux_arbiter_4

Round-robin arbiter that shares one 4:1 datapath multiplexer (four sources, 2-bit select) among four requesters. It samples per-requester request lines, issues a registered one-hot grant, and drives the mux select so the granted source reaches the shared consumer (bus, writeback port, memory interface). Ownership is held until the owner releases. An optional hold limit forces handoff after a bounded tenure.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive owned cycles before forced handoff. Range 1..255. Used only when `ARB_HOLD_LIMIT_EN` is defined.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  4  level request per source; bit i requests mux input i.
- `grant`  out  4  registered one-hot grant; all-zero when idle.
- `select`  out  2  registered mux select, equal to the index of the granted source.
- `busy`  out  1  registered; high whenever any grant bit is high.
- `preempt`  out  1  one-cycle pulse on forced handoff. Present only with `ARB_HOLD_LIMIT_EN`.

## Operation
- FSM states:
  - IDLE: no owner.
  - OWN: one owner.
- Priority pointer `ptr` (2 bits): search order is ptr, ptr+1, ptr+2, ptr+3, mod 4. After any grant to index k, `ptr` becomes k+1 mod 4. Wrap-around from 3 to 0 is natural 2-bit overflow.
- IDLE:
  - If any `req` bit is set, pick the first set bit in search order, grant it, load `select`, and go to OWN.
  - Otherwise stay in IDLE.
- OWN, owner k:
  - While `req[k]` is high, hold `grant` and `select`. Requests from other sources are ignored.
  - When `req[k]` is low, release. If other requests are pending, grant the next source in search order directly, with no idle cycle. Otherwise go to IDLE and clear `grant`.
- `select` keeps its last value in IDLE. It is never changed except on a new grant.
- A request that appears and disappears between two edges is lost. A requester must hold `req` until it sees its grant.
- Reset values: `grant`=0000, `select`=00, `busy`=0, `ptr`=00, state IDLE, `preempt`=0, hold counter=0.
- Reset mid-ownership drops the grant immediately (asynchronously). After reset deassertion, arbitration restarts from `ptr`=0.

## Timing
- Request-to-grant latency: `req` sampled high at edge N produces `grant`/`select`/`busy` valid after edge N, in the cycle following the sampling edge.
- Release-to-handoff latency: owner drops `req` before edge N, and the new owner's grant is visible after edge N. `grant` never has two bits set, and never has a zero-cycle overlap.
- Simultaneous requests are resolved by `ptr` alone.
- If the owner drops its request and re-requests in the same cycle that others are pending, it is treated as a release. The others win.
- All outputs are flops. There is no combinational path from `req` to any output.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle in OWN.
  - When the counter equals `MAX_HOLD`-1, other requests are pending, and the owner's `req` is still high, the arbiter performs a handoff at the next edge. It pulses `preempt` in the same cycle the new grant appears.
  - The preempted source keeps its `req` high. It is re-granted later by normal round-robin.
  - If no other request is pending, the counter saturates at `MAX_HOLD`-1 and ownership continues.
- `ARB_HOLD_LIMIT_EN` undefined: no counter and no `preempt` port. Ownership is unbounded.

## Structure
- Shared package `arb_pkg`:
  - `N_REQ`=4 and `SEL_W`=2.
  - State enum {`ARB_IDLE`, `ARB_OWN`}.
  - `HOLD_W`=8.
- Sub-module `rr_pick4`: combinational. Inputs are `req[3:0]` and `ptr[1:0]`. Outputs are `hit`, `idx[1:0]`, and `onehot[3:0]`. It is used for both the IDLE grant and the handoff.
- Top level holds the FSM, `ptr`, output registers, and the optional hold counter.

## Test plan
- Reset with `req`=1111 held → `grant`=0000, `select`=00, and `busy`=0 during reset. First edge after release gives `grant`=0001, `select`=00.
- `req`=1010 from idle with `ptr`=0 → `grant`=0010, `select`=01. Source 1 drops `req` → next cycle `grant`=1000, `select`=11, with no idle cycle.
- All four requesting continuously, each dropping `req` one cycle after its grant → grant order 0,1,2,3,0 and `select` 00,01,10,11,00. Verifies wrap.
- Owner 2 drops `req` with no other requests → `grant`=0000 and `busy`=0 next cycle, `select` stays 10. Later `req`=0100 → `grant`=0100 (ptr=3 search wraps to 2).
- Assert `reset` while owner 1 is holding → `grant` clears before the next clock edge. After release with `req`=0010, `grant`=0010 after one edge.
- With `ARB_HOLD_LIMIT_EN`, `MAX_HOLD`=4: source 0 holds and source 3 requests → after 4 owned cycles `grant`=1000 and `preempt`=1 for one cycle. Source 3 releases → `grant`=0001 again.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: widths and FSM state encoding.
// Used by mux_arbiter_4 and rr_pick4.
package arb_pkg;
    localparam int N_REQ  = 4;
    localparam int SEL_W  = 2;
    localparam int HOLD_W = 8;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_OWN
    } arb_state_t;
endpackage

// File: rtl/mux_arbiter_4_rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr.
// Shared by the idle grant and the owner handoff paths.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             hit,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);
    logic [SEL_W-1:0] cand;

    always_comb begin
        hit  = 1'b0;
        idx  = ptr;
        cand = ptr;
        // Walk from the farthest slot back so the closest to ptr wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
        onehot = N_REQ'(hit) << idx;
    end
endmodule

// File: rtl/mux_arbiter_4.sv
// Round-robin owner arbiter driving a shared 4:1 mux select.
// Define ARB_HOLD_LIMIT_EN to add the MAX_HOLD tenure limit and preempt.
module mux_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] select,
    output logic             busy
`ifdef ARB_HOLD_LIMIT_EN
    ,
    output logic             preempt
`endif
);
    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic             hit;
    logic [SEL_W-1:0] idx;
    logic [N_REQ-1:0] onehot;
    logic             own_req;
    logic             take;
    logic             release_own;
    logic             force_nxt;

    // The current owner is masked out, so a handoff never re-picks it.
    rr_pick4 u_pick (
        .req    (req & ~grant),
        .ptr    (ptr),
        .hit    (hit),
        .idx    (idx),
        .onehot (onehot)
    );

    assign own_req = req[select];

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt;
    assign force_nxt = (state == ARB_OWN) && own_req
                    && (hold_cnt == HOLD_LAST) && hit;
`else
    assign force_nxt = 1'b0;
`endif

    always_comb begin
        take        = 1'b0;
        release_own = 1'b0;
        unique case (state)
            ARB_IDLE: take = hit;
            ARB_OWN: begin
                release_own = !own_req;
                take        = (release_own && hit) || force_nxt;
            end
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ARB_IDLE;
            ptr    <= '0;
            grant  <= '0;
            select <= '0;
            busy   <= 1'b0;
        end else if (take) begin
            state  <= ARB_OWN;
            grant  <= onehot;
            select <= idx;
            ptr    <= idx + SEL_W'(1);
            busy   <= 1'b1;
        end else if (release_own) begin
            state <= ARB_IDLE;
            grant <= '0;
            busy  <= 1'b0;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= force_nxt;
            if (take)
                hold_cnt <= '0;
            else if (state == ARB_OWN && hold_cnt != HOLD_LAST)
                hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`endif
endmodule
